// File: rtl/serializer_pkg.sv
// Purpose : shared constants for the multi-lane word serializer (TMDS control symbols, default geometry).
// Latency : n/a (constants only).
// Backpressure: n/a.
package serializer_pkg;

    localparam int DEFAULT_CHANNELS = 3;
    localparam int DEFAULT_WIDTH    = 10;

    // TMDS control symbols indexed by {C1,C0}; CTRL_00 doubles as the idle word.
    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

endpackage

// File: rtl/multi_serializer_if.sv
// Purpose : parallel word-set handshake into the serializer (valid/ready, all lanes packed into one bus).
// Latency : n/a (wires only).
// Backpressure: the slave side drives ready; data is only taken when valid && ready.
// Ports   : in_valid, in_data (master -> slave), in_ready (slave -> master).
interface multi_serializer_if
    import serializer_pkg::*;
#(
    parameter int CHANNELS = DEFAULT_CHANNELS,
    parameter int WIDTH    = DEFAULT_WIDTH
) ();

    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*WIDTH-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/ser_lane.sv
// Purpose : one lane's WIDTH-bit parallel-load shift register, bit order chosen by LSB_FIRST.
// Latency : loaded word's first bit is on serial the cycle after the load edge.
// Backpressure: none; load is driven by the shared word timing.
// Ports   : clk, rst (sync, active-high), load, load_word, serial.
module ser_lane #(
    parameter int               WIDTH     = 10,
    parameter bit               LSB_FIRST = 1'b1,
    parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    output logic             serial
);

    logic [WIDTH-1:0] sreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= IDLE_WORD;
        end else if (load) begin
            sreg <= load_word;
        end else if (LSB_FIRST) begin
            sreg <= {1'b0, sreg[WIDTH-1:1]};
        end else begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
        end
    end

    // The output end is the register bit itself, so serial is a registered output.
    assign serial = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];

endmodule

// File: rtl/multi_serializer.sv
// Purpose : CHANNELS-lane word serializer with one shared holding register and idle-word insertion.
// Latency : a word accepted at bit_cnt == WIDTH-2 has its first bit on out_serial 2 cycles later.
// Backpressure: in_ready = hold empty or word boundary; without data, IDLE_WORD is sent and counted once armed.
// Ports   : clk, rst (sync, active-high), bus (slave: in_valid/in_ready/in_data),
//           out_serial[CHANNELS], word_start, underrun_count[16].
module multi_serializer
    import serializer_pkg::*;
#(
    parameter int               CHANNELS  = DEFAULT_CHANNELS,
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter bit               LSB_FIRST = 1'b1,
    parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(TMDS_CTRL_00)
) (
    input  logic                 clk,
    input  logic                 rst,
    multi_serializer_if.slave    bus,
    output logic [CHANNELS-1:0]  out_serial,
    output logic                 word_start,
    output logic [15:0]          underrun_count
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [CW-1:0]             bit_cnt;
    logic [CHANNELS*WIDTH-1:0] hold;
    logic                      hold_valid;
    logic                      armed;
    logic                      at_last;
    logic                      xfer;

    assign at_last      = (bit_cnt == LAST);
    assign bus.in_ready = !hold_valid || at_last;
    assign xfer         = bus.in_valid && bus.in_ready;
    assign word_start   = (bit_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt        <= '0;
            hold           <= '0;
            hold_valid     <= 1'b0;
            armed          <= 1'b0;
            underrun_count <= '0;
        end else begin
            bit_cnt <= at_last ? '0 : bit_cnt + CW'(1);

            // A transfer always leaves hold full. At a boundary the lanes take the
            // old contents, so a word arriving into an empty hold waits a full word.
            if (xfer) begin
                hold       <= bus.in_data;
                hold_valid <= 1'b1;
                armed      <= 1'b1;
            end else if (at_last) begin
                hold_valid <= 1'b0;
            end

            // Idle load at the boundary; uses armed as it was before this edge.
            if (at_last && !hold_valid && armed && (underrun_count != 16'hFFFF)) begin
                underrun_count <= underrun_count + 16'd1;
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        ser_lane #(
            .WIDTH     (WIDTH),
            .LSB_FIRST (LSB_FIRST),
            .IDLE_WORD (IDLE_WORD)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .load      (at_last),
            .load_word (hold_valid ? hold[k*WIDTH +: WIDTH] : IDLE_WORD),
            .serial    (out_serial[k])
        );
    end

endmodule

// File: tb/tb_multi_serializer.sv
// Purpose : self-checking bench for multi_serializer (3 lanes x 10 bits, LSB first).
// Latency : n/a.
// Backpressure: stimulus honours in_ready when streaming.
module tb_multi_serializer;

    localparam int             C    = 3;
    localparam int             W    = 10;
    localparam logic [W-1:0]   IDLE = 10'b1101010100;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [C-1:0]   out_serial;
    logic           word_start;
    logic [15:0]    underrun_count;

    multi_serializer_if #(.CHANNELS(C), .WIDTH(W)) bus ();

    multi_serializer #(
        .CHANNELS  (C),
        .WIDTH     (W),
        .LSB_FIRST (1'b1),
        .IDLE_WORD (IDLE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .out_serial     (out_serial),
        .word_start     (word_start),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Word-level view: accepted word sets queue up (at most one waiting), one word
    // (or idle) is on the wire per 10-cycle period, bit index = cycle within period.
    int               m_phase;
    logic [C*W-1:0]   m_cur;
    logic [C*W-1:0]   m_q[$];
    bit               m_armed;
    int               m_uc;
    bit               m_live = 1'b0;
    bit               m_rdy;
    logic [C*W-1:0]   idle_all;
    logic [C-1:0]     exp_ser;

    initial for (int k = 0; k < C; k++) idle_all[k*W +: W] = IDLE;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_cur   = idle_all;
            m_q.delete();
            m_armed = 1'b0;
            m_uc    = 0;
            m_live  = 1'b1;
        end else begin
            m_rdy = (m_q.size() == 0) || (m_phase == W - 1);
            if (m_phase == W - 1) begin
                if (m_q.size() > 0) begin
                    m_cur = m_q.pop_front();
                end else begin
                    m_cur = idle_all;
                    if (m_armed && m_uc < 65535) m_uc++;
                end
                m_phase = 0;
            end else begin
                m_phase++;
            end
            if (bus.in_valid && m_rdy) begin
                m_q.push_back(bus.in_data);
                m_armed = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            for (int k = 0; k < C; k++) exp_ser[k] = m_cur[k*W + m_phase];
            check("out_serial", 32'(out_serial), 32'(exp_ser));
            check("word_start", 32'(word_start), 32'(m_phase == 0));
            check("in_ready", 32'(bus.in_ready), 32'((m_q.size() == 0) || (m_phase == W - 1)));
            check("underrun_count", 32'(underrun_count), 32'(m_uc));
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [C*W-1:0] words[10];

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_phase_neg(input int p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_phase != p && n < 100);
        if (m_phase != p) check("wait_phase", 32'(m_phase), 32'(p));
    endtask

    // Samples the current negedge first, then the following n-1 negedges.
    task automatic capture(input int lane, input int n, output logic [79:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            v[i] = out_serial[lane];
            if (i < n - 1) @(negedge clk);
        end
    endtask

    task automatic send(input int start, input int n);
        int  idx   = 0;
        int  guard = 0;
        logic r;
        bus.in_valid = 1'b1;
        bus.in_data  = words[start];
        while (idx < n && guard < 400) begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            #1;
            if (r) begin
                idx++;
                if (idx < n) bus.in_data = words[start + idx];
            end
            guard++;
        end
        bus.in_valid = 1'b0;
        if (idx < n) check("send_timeout", 32'(idx), 32'(n));
    endtask

    task automatic stream_and_check(input int start, input int n, input string name);
        logic [79:0] v;
        fork
            send(start, n);
            begin
                // First word is accepted at phase 0, loaded at the phase-9 edge.
                repeat (11) @(negedge clk);
                capture(0, n * W, v);
            end
        join
        for (int i = 0; i < n; i++)
            check(name, 32'(v[i*W +: W]), 32'(words[start + i][W-1:0]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [79:0] v;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        for (int i = 0; i < 10; i++)
            for (int k = 0; k < C; k++)
                words[i][k*W +: W] = W'((i * 173 + k * 59 + 37) % 1024);

        // Reset state and repeating idle pattern.
        do_reset();
        @(negedge clk);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_serial", 32'(out_serial), 32'd0);
        check("reset_word_start", 32'(word_start), 32'd1);
        check("reset_underrun", 32'(underrun_count), 32'd0);
        capture(1, 20, v);
        check("idle_pattern", 32'(v[19:0]), 32'({IDLE, IDLE}));

        // Single word accepted at bit_cnt 8.
        wait_phase_neg(8);
        bus.in_valid = 1'b1;
        bus.in_data  = {10'h3C0, 10'h155, 10'h2AB};
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("single_latency_gap", 32'(word_start), 32'd0);
        @(negedge clk);
        capture(0, 10, v);
        check("single_word_bits", 32'(v[9:0]), 32'h2AB);
        @(negedge clk);
        check("single_underrun", 32'(underrun_count), 32'd1);

        // Starvation: 50 cycles without data after that word.
        repeat (49) @(negedge clk);
        check("starve_underrun", 32'(underrun_count), 32'd5);

        // Back-to-back stream of 8 word sets.
        do_reset();
        stream_and_check(0, 8, "stream_word");

        // Simultaneous unload and transfer at the boundary.
        do_reset();
        stream_and_check(8, 2, "boundary_word");
        repeat (12) @(negedge clk);

        // Mid-word reset with a further word waiting in hold.
        do_reset();
        send(0, 2);
        wait_phase_neg(4);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out_serial", 32'(out_serial), 32'd0);
        check("midrst_word_start", 32'(word_start), 32'd1);
        check("midrst_underrun", 32'(underrun_count), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        capture(0, 20, v);
        check("midrst_no_resume", 32'(v[19:0]), 32'({IDLE, IDLE}));

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
